// File: rtl/mac_rx_pkg.sv
// Shared types and constants for the 10GbE receive ring writer.
// The optional RX_TIMESTAMP_EN build relies on NS_PER_SEC.
package mac_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DROP   = 2'd3
  } rx_state_e;

  // The header word has byte_count in its upper half and the timestamp in its lower half.
  localparam int HDR_LEN_MSB = 63;
  localparam int HDR_LEN_LSB = 32;

  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/rx_ts_gen.sv
// Free-running seconds/nanoseconds timestamp, built only when RX_TIMESTAMP_EN is defined.
// The second rolls over after a whole number of clocks, so ts_nsec restarts from zero.
module rx_ts_gen
  import mac_rx_pkg::*;
#(
  parameter int NS_PER_CLK = 6
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] ts_sec_o,
  output logic [31:0] ts_nsec_o
);

  localparam logic [31:0] CYC_PER_SEC = 32'(NS_PER_SEC / 32'(NS_PER_CLK));
  localparam logic [31:0] NS_STEP     = 32'(NS_PER_CLK);

  logic [31:0] cyc_q;
  logic [31:0] sec_q;
  logic [31:0] nsec_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q  <= 32'd0;
      sec_q  <= 32'd0;
      nsec_q <= 32'd0;
    end else if (cyc_q == CYC_PER_SEC - 32'd1) begin
      cyc_q  <= 32'd0;
      nsec_q <= 32'd0;
      sec_q  <= sec_q + 32'd1;
    end else begin
      cyc_q  <= cyc_q + 32'd1;
      nsec_q <= nsec_q + NS_STEP;
    end
  end

  assign ts_sec_o  = sec_q;
  assign ts_nsec_o = nsec_q;

endmodule

// File: rtl/mac_rx_ring_writer.sv
// Writes XGMII receive frames into a circular buffer as {header, payload...} and publishes
// committed frames through an extended write pointer. Optional header timestamp: RX_TIMESTAMP_EN.
module mac_rx_ring_writer
  import mac_rx_pkg::*;
#(
  parameter int AW         = 9,
  parameter int HEADROOM   = 32,
  parameter int MAX_WORDS  = 190,
  parameter int NS_PER_CLK = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   rx_data,
  input  logic [7:0]    rx_data_valid,
  input  logic          rx_good_frame,
  input  logic          rx_bad_frame,
  output logic [AW-1:0] wr_addr,
  output logic [63:0]   wr_data,
  output logic          wr_en,
  output logic [AW:0]   committed_wr_addr,
  input  logic [AW:0]   rd_addr_ext,
  output logic [31:0]   good_frame_cnt,
  output logic [31:0]   bad_frame_cnt,
  output logic [31:0]   drop_frame_cnt
);

  localparam logic [AW:0] OCC_LIMIT = (AW+1)'((1 << AW) - HEADROOM);
  localparam int          WW        = $clog2(MAX_WORDS + 1);
  localparam logic [WW-1:0] MAX_W   = WW'(MAX_WORDS);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  rx_state_e     state_q;
  logic [AW:0]   committed_q;
  logic [AW:0]   wr_ptr_q;
  logic [WW-1:0] words_q;
  logic [31:0]   bytes_q;
  logic [31:0]   ts_lat_q;
  logic          eof_pend_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [63:0]   wr_data_q;
  logic [31:0]   good_q;
  logic [31:0]   bad_q;
  logic [31:0]   drop_q;

  logic [AW:0]   occ_d;
  logic          beat_vld_d;
  logic          drop_d;
  logic [31:0]   bytes_d;
  logic [31:0]   ts_now_d;

`ifdef RX_TIMESTAMP_EN
  logic [31:0] ts_sec;

  rx_ts_gen #(
    .NS_PER_CLK(NS_PER_CLK)
  ) u_ts (
    .clk      (clk),
    .reset    (reset),
    .ts_sec_o (ts_sec),
    .ts_nsec_o(ts_now_d)
  );
`else
  assign ts_now_d = 32'd0;
`endif

  // Occupancy counts everything from the consumer pointer up to the next payload slot,
  // including the uncommitted part of the frame in flight.
  assign occ_d      = wr_ptr_q - rd_addr_ext;
  assign beat_vld_d = |rx_data_valid;
  assign bytes_d    = bytes_q + {28'd0, popcnt8(rx_data_valid)};
  assign drop_d     = (occ_d > OCC_LIMIT) || ((words_q == MAX_W) && beat_vld_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      committed_q <= '0;
      wr_ptr_q    <= '0;
      words_q     <= '0;
      bytes_q     <= 32'd0;
      ts_lat_q    <= 32'd0;
      eof_pend_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 64'd0;
      good_q      <= 32'd0;
      bad_q       <= 32'd0;
      drop_q      <= 32'd0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          wr_ptr_q <= committed_q + 1'b1;
          if (beat_vld_d) begin
            state_q  <= ST_DATA;
            words_q  <= '0;
            bytes_q  <= 32'd0;
            ts_lat_q <= ts_now_d;
          end
        end
        ST_DATA: begin
          if (drop_d) begin
            state_q    <= ST_DROP;
            eof_pend_q <= rx_good_frame | rx_bad_frame;
          end else begin
            if (beat_vld_d) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= wr_ptr_q[AW-1:0];
              wr_data_q <= rx_data;
              wr_ptr_q  <= wr_ptr_q + 1'b1;
              words_q   <= words_q + 1'b1;
            end
            bytes_q <= bytes_d;
            if (rx_good_frame) begin
              state_q <= ST_COMMIT;
            end else if (rx_bad_frame) begin
              state_q <= ST_IDLE;
              bad_q   <= sat_inc(bad_q);
            end
          end
        end
        ST_COMMIT: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= committed_q[AW-1:0];
          wr_data_q[HDR_LEN_MSB:HDR_LEN_LSB] <= bytes_q;
          wr_data_q[HDR_LEN_LSB-1:0]         <= ts_lat_q;
          committed_q <= wr_ptr_q;
          good_q      <= sat_inc(good_q);
          wr_ptr_q    <= wr_ptr_q + 1'b1;
          words_q     <= '0;
          bytes_q     <= 32'd0;
          // A preamble here starts the next frame straight after this header slot.
          if (beat_vld_d) begin
            state_q  <= ST_DATA;
            ts_lat_q <= ts_now_d;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (eof_pend_q || rx_good_frame || rx_bad_frame) begin
            state_q    <= ST_IDLE;
            eof_pend_q <= 1'b0;
            drop_q     <= sat_inc(drop_q);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_en             = wr_en_q;
  assign wr_addr           = wr_addr_q;
  assign wr_data           = wr_data_q;
  assign committed_wr_addr = committed_q;
  assign good_frame_cnt    = good_q;
  assign bad_frame_cnt     = bad_q;
  assign drop_frame_cnt    = drop_q;

endmodule

// File: doc/mac_rx_ring_writer.md
Name: mac_rx_ring_writer

Overview:
- Parametrised next generation of the 10GbE MAC receive front end.
- Takes XGMII-style 64-bit beats from the MAC core and writes each frame into a circular packet buffer of 2^AW 64-bit words.
- Each frame is stored as one header word followed by its payload words. Committed frames are published to the DMA/TLP side through an extended write pointer.
- Adds configurable depth, headroom and max frame length, exact occupancy tracking, and per-cause statistics counters.

Parameters:
- AW, 9, buffer word-address width; depth = 2^AW words.
- HEADROOM, 32, a frame is dropped once occupancy exceeds 2^AW - HEADROOM words.
- MAX_WORDS, 190, maximum payload words per frame; longer frames are dropped.
- NS_PER_CLK, 6, timestamp nanosecond increment per clk (used only with the optional feature).

Ports:
- clk  in  1  core clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  64  MAC receive data.
- rx_data_valid  in  8  byte-lane valid, lane 0 = bits 7:0.
- rx_good_frame  in  1  EOF pulse, frame good.
- rx_bad_frame  in  1  EOF pulse, frame bad.
- wr_addr  out  AW  buffer write address.
- wr_data  out  64  buffer write data.
- wr_en  out  1  buffer write strobe.
- committed_wr_addr  out  AW+1  extended address of the next header slot; all words below it are valid.
- rd_addr_ext  in  AW+1  consumer extended read pointer, already synchronous to clk.
- good_frame_cnt  out  32  committed frames.
- bad_frame_cnt  out  32  frames ended by rx_bad_frame.
- drop_frame_cnt  out  32  frames dropped for space or length.

Behaviour:
- Reset: all outputs 0; state IDLE; all pointers 0.
- Frame layout at start address S:
  - S = header, {byte_count[31:0], ts[31:0] or 32'b0}.
  - S+1 onward = payload beats in arrival order.
  - Next frame starts at S+1+payload_words.
  - All address arithmetic wraps mod 2^(AW+1); wr_addr = low AW bits.
- occ = (wr_ptr - rd_addr_ext) mod 2^(AW+1), computed combinationally each cycle; wr_ptr is the next payload address.
- States: IDLE, DATA, COMMIT, DROP.
- IDLE: wr_en=0; wr_ptr = committed+1. The first beat with rx_data_valid != 0 is the preamble: it is not written and moves the FSM to DATA.
- DATA, per beat:
  - If rx_data_valid != 0: write rx_data at wr_ptr, registered, so it appears on wr_* 1 cycle later. Increment wr_ptr and payload word count.
  - byte_count += popcount(rx_data_valid).
  - Valid == 0 beats write nothing.
  - Priority in one cycle: (occ > 2^AW - HEADROOM) or (words == MAX_WORDS and valid != 0) -> DROP. Else rx_good_frame -> COMMIT. Else rx_bad_frame -> IDLE, bad_frame_cnt++.
  - The beat carrying EOF is written if its valid != 0.
- COMMIT, exactly 1 cycle:
  - Header written at old committed address.
  - committed_wr_addr <= wr_ptr, changing on the same edge the header wr_en is driven.
  - good_frame_cnt++.
  - If rx_data_valid != 0 (back-to-back preamble) -> DATA with wr_ptr = new committed+1; else -> IDLE.
- DROP:
  - wr_en=0; no commit. Payload already written is later overwritten.
  - Exit to IDLE on rx_good_frame or rx_bad_frame, including one registered 1 cycle earlier; drop_frame_cnt++.
  - If EOF coincides with the drop decision, the drop wins and is counted once.
- Counters saturate at 2^32-1.
- Reset mid-frame discards the partial frame; committed_wr_addr returns to 0, and the consumer must reset together with this block.

Optional Feature:
- RX_TIMESTAMP_EN defined:
  - Free-running ts_sec/ts_nsec; ts_nsec += NS_PER_CLK per cycle.
  - Second rollover when the cycle count reaches 10^9/NS_PER_CLK cycles: ts_nsec <= 0, ts_sec++.
  - ts_nsec is latched at the preamble beat and placed in header bits 31:0.
- Not defined: header bits 31:0 = 0; the timestamp logic is absent.

Decomposition:
- Package mac_rx_pkg: state enum; HDR_LEN_MSB/LSB field constants; NS_PER_SEC constant.
- One sub-module, rx_ts_gen: the timestamp generator, instantiated only under RX_TIMESTAMP_EN.

Test Plan:
- Single 64-byte good frame (preamble + 8 full beats), rd_addr_ext=0 -> words 1..8 = data; word 0 = {32'd64, ts|0}; committed_wr_addr = 9; good_frame_cnt = 1.
- Frame ending with valid=8'h0F after 7 full beats -> byte_count = 60, 8 payload words, committed advances by 9.
- Bad-frame EOF after 3 beats -> committed_wr_addr unchanged; bad_frame_cnt = 1; the next good frame reuses the same start address.
- AW=9, HEADROOM=32, rd_addr_ext held at 0, continuous frames -> drop when occ exceeds 480; drop_frame_cnt increments once per dropped frame; no commit past 480 words; advancing rd_addr_ext lets later frames commit.
- Back-to-back frames (preamble in the COMMIT cycle) -> both frames committed; second header at 9; no beat lost.
- Wrap: committed = 510, 3-word frame -> payload at 511, 0, 1; committed_wr_addr = 514 (extended); MAX_WORDS+1 beats -> DROP.
